// File: rtl/nibbler_pkg.sv
// rtl/nibbler_pkg.sv - shared widths, state type and read-mode codes for the Nibbler RAM
package nibbler_pkg;

   localparam int NIB_DATA_W = 4;
   localparam int NIB_ADDR_W = 12;

   typedef enum logic {RAM_CLEAR, RAM_IDLE} ram_state_t;

   // Value presented on data_out for a write cycle
   localparam int RAM_READ_FIRST  = 0;   // pre-write contents
   localparam int RAM_WRITE_FIRST = 1;   // the data being written

endpackage

// File: rtl/nibbler_ram_array.sv
// rtl/nibbler_ram_array.sv - synchronous single-port storage with registered read, no reset
//
// Ports:
//   clk    - rising-edge clock
//   we     - write enable for this edge
//   addr   - word index
//   wdata  - write data
//   rdata  - registered read of addr, taken before any same-edge write
module nibbler_ram_array #(
   parameter int DATA_W = 4,
   parameter int IDX_W  = 12,
   parameter int DEPTH  = 4096
) (
   input  logic              clk,
   input  logic              we,
   input  logic [IDX_W-1:0]  addr,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] rdata
);

   logic [DATA_W-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[addr] <= wdata;
      end
      rdata <= mem[addr];
   end

endmodule

// File: rtl/nibbler_sync_ram.sv
// rtl/nibbler_sync_ram.sv - clocked Nibbler RAM with clear sequencer, range check and read-mode select
//
// Ports:
//   clk       - rising-edge clock
//   notReset  - asynchronous active-low reset
//   address   - word address
//   notCs     - active-low chip select
//   notWe     - active-low write enable, meaningful only with notCs=0
//   data_in   - write data
//   data_out  - registered read data, held between accesses
//   data_oe   - drive enable for the shared tri-state bus (same as rd_valid)
//   rd_valid  - one-cycle pulse after an accepted read
//   busy      - clear sequencer running; all accesses are dropped
//   addr_err  - one-cycle pulse after an accepted access with address >= DEPTH
module nibbler_sync_ram
   import nibbler_pkg::*;
#(
   parameter int DATA_W         = NIB_DATA_W,
   parameter int ADDR_W         = NIB_ADDR_W,
   parameter int DEPTH          = 1 << NIB_ADDR_W,
   parameter int READ_MODE      = RAM_READ_FIRST,
   parameter int CLEAR_ON_RESET = 1
) (
   input  logic              clk,
   input  logic              notReset,
   input  logic [ADDR_W-1:0] address,
   input  logic              notCs,
   input  logic              notWe,
   input  logic [DATA_W-1:0] data_in,
   output logic [DATA_W-1:0] data_out,
   output logic              data_oe,
   output logic              rd_valid,
   output logic              busy,
   output logic              addr_err
);

   localparam int              IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [ADDR_W:0] DEPTH_C  = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W:0] LAST_C   = (ADDR_W+1)'(DEPTH - 1);
   localparam bit              FULL_MAP = (DEPTH == (1 << ADDR_W));

   ram_state_t        state_q, state_d;
   logic [ADDR_W:0]   cnt_q;          // one bit wider so DEPTH = 2**ADDR_W never wraps
   logic              accept;
   logic              in_range;
   logic              ram_we;
   logic [IDX_W-1:0]  ram_addr;
   logic [DATA_W-1:0] ram_wdata;
   logic [DATA_W-1:0] ram_q;
   logic              src_ram_q;      // data_out comes straight from the array register
   logic [DATA_W-1:0] hold_q;
   logic              rd_valid_q;
   logic              addr_err_q;

   assign busy     = (state_q == RAM_CLEAR);
   assign accept   = !busy && !notCs;
   assign in_range = FULL_MAP || ({1'b0, address} < DEPTH_C);

   always_ff @(posedge clk or negedge notReset) begin
      if (!notReset) begin
         state_q <= (CLEAR_ON_RESET != 0) ? RAM_CLEAR : RAM_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      if (state_q == RAM_CLEAR && cnt_q == LAST_C) begin
         state_d = RAM_IDLE;
      end
   end

   always_ff @(posedge clk or negedge notReset) begin
      if (!notReset) begin
         cnt_q <= '0;
      end else if (busy) begin
         cnt_q <= cnt_q + 1'b1;
      end
   end

   // Out-of-range writes never reach the array, so aliasing in the truncated index is harmless.
   always_comb begin
      ram_we    = busy || (accept && !notWe && in_range);
      ram_addr  = busy ? cnt_q[IDX_W-1:0] : address[IDX_W-1:0];
      ram_wdata = busy ? '0 : data_in;
   end

   nibbler_ram_array #(
      .DATA_W (DATA_W),
      .IDX_W  (IDX_W),
      .DEPTH  (DEPTH)
   ) u_array (
      .clk   (clk),
      .we    (ram_we),
      .addr  (ram_addr),
      .wdata (ram_wdata),
      .rdata (ram_q)
   );

   // The array register is used directly for in-range reads and read-first writes; every
   // other case (hold, out-of-range, write-first) goes through hold_q, which also snapshots
   // the visible value so data_out stays put while the array register moves on.
   always_ff @(posedge clk or negedge notReset) begin
      if (!notReset) begin
         src_ram_q  <= 1'b0;
         hold_q     <= '0;
         rd_valid_q <= 1'b0;
         addr_err_q <= 1'b0;
      end else begin
         rd_valid_q <= accept && notWe;
         addr_err_q <= accept && !in_range;
         hold_q     <= data_out;
         src_ram_q  <= 1'b0;
         if (accept) begin
            if (!in_range) begin
               hold_q <= '0;
            end else if (!notWe && READ_MODE == RAM_WRITE_FIRST) begin
               hold_q <= data_in;
            end else begin
               src_ram_q <= 1'b1;
            end
         end
      end
   end

   assign data_out = src_ram_q ? ram_q : hold_q;
   assign rd_valid = rd_valid_q;
   assign data_oe  = rd_valid_q;
   assign addr_err = addr_err_q;

endmodule

// File: tb/tb_nibbler_sync_ram.sv
// tb/tb_nibbler_sync_ram.sv - scoreboard bench for nibbler_sync_ram in both read modes
module tb_nibbler_sync_ram;

   localparam int DW  = 4;
   localparam int AW  = 12;
   localparam int DEP = 16;

   logic          clk = 1'b0;
   logic          notReset = 1'b0;
   logic          notCs = 1'b1;
   logic          notWe = 1'b1;
   logic [AW-1:0] address = '0;
   logic [DW-1:0] data_in = '0;

   logic [DW-1:0] dout0, dout1;
   logic          oe0, oe1, rv0, rv1, busy0, busy1, err0, err1;

   always #5 clk = ~clk;

   nibbler_sync_ram #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEP), .READ_MODE(0), .CLEAR_ON_RESET(1)) dut_rf (
      .clk(clk), .notReset(notReset), .address(address), .notCs(notCs), .notWe(notWe),
      .data_in(data_in), .data_out(dout0), .data_oe(oe0), .rd_valid(rv0), .busy(busy0),
      .addr_err(err0)
   );

   nibbler_sync_ram #(.DATA_W(DW), .ADDR_W(AW), .DEPTH(DEP), .READ_MODE(1), .CLEAR_ON_RESET(1)) dut_wf (
      .clk(clk), .notReset(notReset), .address(address), .notCs(notCs), .notWe(notWe),
      .data_in(data_in), .data_out(dout1), .data_oe(oe1), .rd_valid(rv1), .busy(busy1),
      .addr_err(err1)
   );

   typedef struct {
      logic          busy;
      logic          rv;
      logic          err;
      logic [DW-1:0] d0;
      logic [DW-1:0] d1;
   } exp_t;

   exp_t          exq[$];
   int            total = 0;
   int            bad   = 0;

   // Reference model: word contents, cycles of clearing left, last value shown per mode
   logic [DW-1:0] mem_m [DEP];
   int            clear_left = 0;
   logic [DW-1:0] out0_m = '0;
   logic [DW-1:0] out1_m = '0;

   task automatic chk(input string nm, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Called at a falling edge: drives one cycle of stimulus, queues the expected
   // post-edge outputs, and returns at the next falling edge.
   task automatic cycle(input logic cs_n, input logic we_n, input int a, input int d);
      exp_t e;
      notCs   = cs_n;
      notWe   = we_n;
      address = AW'(a);
      data_in = DW'(d);
      e.rv  = 1'b0;
      e.err = 1'b0;
      if (clear_left > 0) begin
         clear_left--;
      end else if (!cs_n) begin
         e.rv = we_n;
         if (a >= DEP) begin
            e.err  = 1'b1;
            out0_m = '0;
            out1_m = '0;
         end else if (we_n) begin
            out0_m = mem_m[a];
            out1_m = mem_m[a];
         end else begin
            out0_m   = mem_m[a];
            out1_m   = DW'(d);
            mem_m[a] = DW'(d);
         end
      end
      e.busy = (clear_left > 0);
      e.d0   = out0_m;
      e.d1   = out1_m;
      exq.push_back(e);
      @(negedge clk);
   endtask

   // Called at a falling edge; releases reset at a falling edge so the next rising
   // edge is the first clear write.
   task automatic do_reset(input int hold_cycles);
      notReset = 1'b0;
      notCs    = 1'b1;
      notWe    = 1'b1;
      exq.delete();
      repeat (hold_cycles) @(negedge clk);
      chk("reset_dout_rf", dout0, 0);
      chk("reset_dout_wf", dout1, 0);
      chk("reset_rv", rv0 | rv1, 0);
      chk("reset_oe", oe0 | oe1, 0);
      chk("reset_err", err0 | err1, 0);
      chk("reset_busy", busy0 & busy1, 1);
      foreach (mem_m[i]) mem_m[i] = '0;
      out0_m     = '0;
      out1_m     = '0;
      clear_left = DEP;
      notReset   = 1'b1;
   endtask

   initial begin
      forever begin
         @(posedge clk);
         #3;
         if (exq.size() > 0) begin
            exp_t e;
            e = exq.pop_front();
            chk("busy_rf", busy0, e.busy);
            chk("busy_wf", busy1, e.busy);
            chk("rd_valid_rf", rv0, e.rv);
            chk("rd_valid_wf", rv1, e.rv);
            chk("data_oe_rf", oe0, e.rv);
            chk("data_oe_wf", oe1, e.rv);
            chk("addr_err_rf", err0, e.err);
            chk("addr_err_wf", err1, e.err);
            chk("data_out_rf", dout0, e.d0);
            chk("data_out_wf", dout1, e.d1);
         end
      end
   end

   initial begin
      @(negedge clk);
      do_reset(3);
      // Writes to address 2 while clearing must be dropped
      for (int i = 0; i < DEP; i++) cycle(1'b0, 1'b0, 2, 5);
      for (int i = 0; i < DEP; i++) cycle(1'b0, 1'b1, i, 0);
      cycle(1'b1, 1'b1, 0, 0);

      // Reset again, then interrupt the clear at cycle 7
      do_reset(2);
      for (int i = 0; i < 7; i++) cycle(1'b1, 1'b1, 0, 0);
      do_reset(2);
      for (int i = 0; i < DEP; i++) cycle(1'b0, 1'b0, 2, 5);
      for (int i = 0; i < DEP; i++) cycle(1'b0, 1'b1, i, 0);

      // Write then read back-to-back, then idle hold
      cycle(1'b0, 1'b0, 3, 'hA);
      cycle(1'b0, 1'b1, 3, 0);
      cycle(1'b1, 1'b1, 0, 0);
      cycle(1'b1, 1'b1, 0, 0);

      // Read-first versus write-first on a write cycle
      cycle(1'b0, 1'b0, 5, 'h3);
      cycle(1'b0, 1'b0, 5, 'hC);
      cycle(1'b1, 1'b1, 0, 0);

      // Out of range: 20 aliases index 4 in the array, so word 4 must survive
      cycle(1'b0, 1'b0, 4, 'h6);
      cycle(1'b0, 1'b0, 20, 'hF);
      cycle(1'b0, 1'b1, 20, 0);
      cycle(1'b0, 1'b1, 4, 0);
      cycle(1'b0, 1'b1, 4095, 0);

      repeat (400) begin
         int a;
         a = ($urandom_range(0, 7) == 0) ? int'($urandom_range(DEP, 4095)) : int'($urandom_range(0, DEP - 1));
         cycle($urandom_range(0, 3) == 0, 1'($urandom_range(0, 1)), a, int'($urandom_range(0, 15)));
      end
      cycle(1'b1, 1'b1, 0, 0);
      cycle(1'b1, 1'b1, 0, 0);

      @(posedge clk);
      #5;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
